plugboard_cfg_ctrl: RTL and testbench

//  Sequences configuration of the plugboard swap LUT (slots A..J = 0..9).

---
 rtl/enigma_pkg.sv | 23 ++
 rtl/plugboard_cfg_ctrl.sv | 167 ++++++++++++++++
 tb/tb_plugboard_cfg_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/enigma_pkg.sv
// rtl/enigma_pkg.sv - shared types and constants for the enigma plugboard configuration path
package enigma_pkg;

  localparam int PB_NUM_SLOTS = 10;
  localparam int PB_CW        = 5;

  typedef logic [PB_CW-1:0] char_t;

  typedef enum logic [1:0] {
    PB_CLEAR  = 2'd0,
    PB_ADD    = 2'd1,
    PB_REMOVE = 2'd2,
    PB_COMMIT = 2'd3
  } pb_op_e;

  typedef enum logic [1:0] {
    PB_OK       = 2'd0,
    PB_RANGE    = 2'd1,
    PB_SELF     = 2'd2,
    PB_CONFLICT = 2'd3
  } pb_err_e;

endpackage

// File: rtl/plugboard_cfg_ctrl.sv
// rtl/plugboard_cfg_ctrl.sv - plugboard swap LUT config sequencer (shadow edit, idle-gated commit)
// Optional feature: PB_READBACK_EN adds rb_sel/rb_data shadow-table readback.
module plugboard_cfg_ctrl
  import enigma_pkg::*;
#(
  parameter int NUM_SLOTS = PB_NUM_SLOTS,
  parameter int CW        = PB_CW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [CW-1:0]           cmd_a,
  input  logic [CW-1:0]           cmd_b,
  output logic                    rsp_valid,
  output logic [1:0]              rsp_err,
  input  logic                    dp_busy,
  output logic [NUM_SLOTS*CW-1:0] pb_lut,
  output logic [2:0]              pair_cnt
`ifdef PB_READBACK_EN
  ,
  input  logic [CW-1:0]           rb_sel,
  output logic [CW-1:0]           rb_data
`endif
);

  localparam int            CNT_W  = $clog2(NUM_SLOTS + 1);
  localparam logic [CW-1:0] NS_C   = CW'(NUM_SLOTS);
  localparam logic [CW-1:0] LAST_C = CW'(NUM_SLOTS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_WR_A, S_WR_B, S_CLR, S_CMT_WAIT, S_RESP
  } state_e;

  state_e         state;
  pb_op_e         op_q;
  logic [CW-1:0]  a_q, b_q, clr_idx;
  logic [CW-1:0]  shadow [NUM_SLOTS];
  logic [CW-1:0]  active [NUM_SLOTS];
  logic [CW-1:0]  sh_a, sh_b, wr_a_val, wr_b_val;
  logic [CNT_W-1:0] sh_cnt;
  logic           a_rng, b_rng;

  // Decoded lookups avoid indexing the table with an out-of-range letter.
  always_comb begin
    sh_a   = a_q;
    sh_b   = b_q;
    sh_cnt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (a_q == CW'(i)) sh_a = shadow[i];
      if (b_q == CW'(i)) sh_b = shadow[i];
      if (shadow[i] != CW'(i)) sh_cnt = sh_cnt + CNT_W'(1);
    end
  end

  assign a_rng = (a_q >= NS_C);
  assign b_rng = (b_q >= NS_C);

  // REMOVE reuses b_q to hold the old partner, so both writes restore identity.
  assign wr_a_val = (op_q == PB_ADD) ? b_q : a_q;
  assign wr_b_val = (op_q == PB_ADD) ? a_q : b_q;

  always_comb begin
    pb_lut = '0;
    for (int i = 0; i < NUM_SLOTS; i++) pb_lut[i*CW +: CW] = active[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= PB_CLEAR;
      a_q       <= '0;
      b_q       <= '0;
      clr_idx   <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= PB_OK;
      pair_cnt  <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        shadow[i] <= CW'(i);
        active[i] <= CW'(i);
      end
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            op_q      <= pb_op_e'(cmd_op);
            a_q       <= cmd_a;
            b_q       <= cmd_b;
            clr_idx   <= '0;
            unique case (pb_op_e'(cmd_op))
              PB_CLEAR:  state <= S_CLR;
              PB_COMMIT: state <= S_CMT_WAIT;
              default:   state <= S_CHECK;
            endcase
          end
        end
        S_CHECK: begin
          if (op_q == PB_ADD) begin
            if (a_rng || b_rng) begin
              rsp_err <= PB_RANGE;  rsp_valid <= 1'b1; state <= S_RESP;
            end else if (a_q == b_q) begin
              rsp_err <= PB_SELF;   rsp_valid <= 1'b1; state <= S_RESP;
            end else if (sh_a != a_q || sh_b != b_q) begin
              rsp_err <= PB_CONFLICT; rsp_valid <= 1'b1; state <= S_RESP;
            end else begin
              state <= S_WR_A;
            end
          end else if (a_rng) begin
            rsp_err <= PB_RANGE; rsp_valid <= 1'b1; state <= S_RESP;
          end else if (sh_a == a_q) begin
            rsp_err <= PB_OK;    rsp_valid <= 1'b1; state <= S_RESP;
          end else begin
            b_q   <= sh_a;
            state <= S_WR_A;
          end
        end
        S_WR_A: begin
          for (int i = 0; i < NUM_SLOTS; i++)
            if (a_q == CW'(i)) shadow[i] <= wr_a_val;
          state <= S_WR_B;
        end
        S_WR_B: begin
          for (int i = 0; i < NUM_SLOTS; i++)
            if (b_q == CW'(i)) shadow[i] <= wr_b_val;
          rsp_err <= PB_OK; rsp_valid <= 1'b1; state <= S_RESP;
        end
        S_CLR: begin
          for (int i = 0; i < NUM_SLOTS; i++)
            if (clr_idx == CW'(i)) shadow[i] <= CW'(i);
          if (clr_idx == LAST_C) begin
            rsp_err <= PB_OK; rsp_valid <= 1'b1; state <= S_RESP;
          end else begin
            clr_idx <= clr_idx + CW'(1);
          end
        end
        S_CMT_WAIT: begin
          if (!dp_busy) begin
            for (int i = 0; i < NUM_SLOTS; i++) active[i] <= shadow[i];
            pair_cnt  <= 3'(sh_cnt >> 1);
            rsp_err   <= PB_OK;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PB_READBACK_EN
  always_ff @(posedge clk) begin
    rb_data <= rb_sel;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (rb_sel == CW'(i)) rb_data <= shadow[i];
  end
`endif

endmodule

// File: tb/tb_plugboard_cfg_ctrl.sv
// tb/tb_plugboard_cfg_ctrl.sv - scoreboard bench for plugboard_cfg_ctrl (PB_READBACK_EN optional)
module tb_plugboard_cfg_ctrl;
  import enigma_pkg::*;

  localparam int NS = PB_NUM_SLOTS;
  localparam int CW = PB_CW;

  typedef int map_t [NS];
  typedef struct {
    logic [1:0] err;
    int         lat;
    int         acc;
    string      name;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = 2'd0;
  char_t             cmd_a = '0;
  char_t             cmd_b = '0;
  logic              rsp_valid;
  logic [1:0]        rsp_err;
  logic              dp_busy = 1'b0;
  logic [NS*CW-1:0]  pb_lut;
  logic [2:0]        pair_cnt;
`ifdef PB_READBACK_EN
  char_t             rb_sel = '0;
  char_t             rb_data;
`endif

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  map_t ident;

  plugboard_cfg_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .dp_busy(dp_busy), .pb_lut(pb_lut), .pair_cnt(pair_cnt)
`ifdef PB_READBACK_EN
    , .rb_sel(rb_sel), .rb_data(rb_data)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, want);
    end
  endtask

  task automatic check_lut(input map_t m, input string nm);
    logic [NS*CW-1:0] want;
    want = '0;
    for (int i = 0; i < NS; i++) want[i*CW +: CW] = CW'(m[i]);
    check(nm, 64'(pb_lut), 64'(want));
  endtask

  // lat < 0 marks a command that must never respond (aborted by reset).
  task automatic issue(input pb_op_e op, input int a, input int b, input pb_err_e err,
                       input int lat, input string nm);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = CW'(a);
    cmd_b     = CW'(b);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: cmd_ready still 0 after 100 cycles, required 1", nm);
    end else if (lat > 0) begin
      exp_q.push_back('{err, lat, cyc, nm});
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d responses outstanding, required 0", nm, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

`ifdef PB_READBACK_EN
  task automatic rb_check(input int sel, input int want, input string nm);
    @(negedge clk);
    rb_sel = CW'(sel);
    @(negedge clk);
    check(nm, 64'(rb_data), 64'(want));
  endtask
`endif

  // Monitor: every response is matched against the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: rsp_valid=1 err=%0d with nothing outstanding", rsp_err);
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_err"}, 64'(rsp_err), 64'(e.err));
          check({e.name, "_lat"}, 64'(cyc - e.acc), 64'(e.lat));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < NS; i++) ident[i] = i;

    // 1: reset state, then an empty commit
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_pair_cnt", 64'(pair_cnt), 64'd0);
    check_lut(ident, "rst_lut");
    rst = 1'b0;
    n = 0;
    while (!cmd_ready && n < 3) begin
      @(negedge clk);
      n++;
    end
    check("post_rst_ready", 64'(cmd_ready), 64'd1);
    issue(PB_COMMIT, 0, 0, PB_OK, 2, "commit0");
    wait_done("t1");
    check_lut(ident, "commit0_lut");
    check("commit0_pairs", 64'(pair_cnt), 64'd0);

    // 2: add goes to shadow only until commit
    issue(PB_ADD, 0, 4, PB_OK, 4, "add_0_4");
    wait_done("t2a");
    check_lut(ident, "add_no_active_change");
    issue(PB_COMMIT, 0, 0, PB_OK, 2, "commit1");
    wait_done("t2b");
    check_lut('{4, 1, 2, 3, 0, 5, 6, 7, 8, 9}, "commit1_lut");
    check("commit1_pairs", 64'(pair_cnt), 64'd1);

    // 3: error paths and idempotent remove
    issue(PB_ADD, 2, 12, PB_RANGE, 2, "add_range");
    issue(PB_ADD, 3, 3, PB_SELF, 2, "add_self");
    issue(PB_ADD, 4, 7, PB_CONFLICT, 2, "add_conf_a");
    issue(PB_ADD, 7, 0, PB_CONFLICT, 2, "add_conf_b");
    issue(PB_ADD, 10, 10, PB_RANGE, 2, "add_range_prio");
    issue(PB_REMOVE, 11, 0, PB_RANGE, 2, "rem_range");
    issue(PB_REMOVE, 9, 0, PB_OK, 2, "rem_idem");
    wait_done("t3");
`ifdef PB_READBACK_EN
    rb_check(4, 0, "rb_slot4");
    rb_check(0, 4, "rb_slot0");
    rb_check(2, 2, "rb_slot2");
    rb_check(3, 3, "rb_slot3");
    rb_check(7, 7, "rb_slot7");
    rb_check(12, 12, "rb_oob");
`endif

    // 4: fill to five pairs, then commit held off by a busy datapath
    issue(PB_ADD, 1, 2, PB_OK, 4, "add_1_2");
    issue(PB_ADD, 3, 5, PB_OK, 4, "add_3_5");
    issue(PB_ADD, 6, 7, PB_OK, 4, "add_6_7");
    issue(PB_ADD, 8, 9, PB_OK, 4, "add_8_9");
    wait_done("t4a");
    dp_busy = 1'b1;
    issue(PB_COMMIT, 0, 0, PB_OK, 8, "commit_busy");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_lut('{4, 1, 2, 3, 0, 5, 6, 7, 8, 9}, "busy_lut_stable");
    end
    @(negedge clk);
    check_lut('{4, 1, 2, 3, 0, 5, 6, 7, 8, 9}, "busy_lut_last");
    dp_busy = 1'b0;
    @(negedge clk);
    check_lut('{4, 2, 1, 5, 0, 3, 7, 6, 9, 8}, "commit_busy_lut");
    check("commit_busy_pairs", 64'(pair_cnt), 64'd5);
    wait_done("t4b");

    // 5: remove, clear, commit
    issue(PB_REMOVE, 4, 0, PB_OK, 4, "rem_4");
    issue(PB_COMMIT, 0, 0, PB_OK, 2, "commit_rem");
    wait_done("t5a");
    check_lut('{0, 2, 1, 5, 4, 3, 7, 6, 9, 8}, "commit_rem_lut");
    check("commit_rem_pairs", 64'(pair_cnt), 64'd4);
    issue(PB_CLEAR, 0, 0, PB_OK, 11, "clear");
    wait_done("t5b");
    check_lut('{0, 2, 1, 5, 4, 3, 7, 6, 9, 8}, "clear_no_active_change");
    issue(PB_COMMIT, 0, 0, PB_OK, 2, "commit_clr");
    wait_done("t5c");
    check_lut(ident, "commit_clr_lut");
    check("commit_clr_pairs", 64'(pair_cnt), 64'd0);

    // 6: reset while ADD(1,2) is in WR_A
    issue(PB_ADD, 5, 6, PB_OK, 4, "add_5_6");
    issue(PB_COMMIT, 0, 0, PB_OK, 2, "commit_pre_rst");
    wait_done("t6a");
    check("pre_rst_pairs", 64'(pair_cnt), 64'd1);
    issue(PB_ADD, 1, 2, PB_OK, -1, "add_aborted");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_ready", 64'(cmd_ready), 64'd0);
    rst = 1'b0;
    check_lut(ident, "abort_lut");
    check("abort_pairs", 64'(pair_cnt), 64'd0);
    n = 0;
    while (!cmd_ready && n < 3) begin
      @(negedge clk);
      n++;
    end
    check("abort_ready", 64'(cmd_ready), 64'd1);
    issue(PB_COMMIT, 0, 0, PB_OK, 2, "commit_post_rst");
    wait_done("t6b");
    check_lut(ident, "post_rst_lut");
    check("post_rst_pairs", 64'(pair_cnt), 64'd0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
